fsk_symbol_sequencer: RTL and testbench

//  Upstream control stage for the 9-bit preloadable frequency divider in the FSK modulator.

---
 rtl/fsk_pkg.sv | 21 ++
 rtl/baud_tick_gen.sv | 35 +++
 rtl/fsk_symbol_sequencer.sv | 118 +++++++++++
 tb/tb_fsk_symbol_sequencer.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/fsk_pkg.sv
// Shared definitions for the FSK modulator control path.
//   state_t           : frame sequencer states
//   PRELOAD_W         : width of the divider preload bus
//   MARK/SPACE_*_DEF  : default divider preloads, shared with the divider bench
package fsk_pkg;

  localparam int unsigned PRELOAD_W = 9;

  // 256 -> 2*256-clk tone period (mark, logic 1 / idle / stop)
  localparam logic [PRELOAD_W-1:0] MARK_PRELOAD_DEF  = 9'd256;
  // 384 -> 2*128-clk tone period (space, logic 0 / start)
  localparam logic [PRELOAD_W-1:0] SPACE_PRELOAD_DEF = 9'd384;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer for the FSK symbol sequencer.
// Counts 0..BAUD_DIV-1 and wraps; a synchronous clear holds it at 0.
//   clk       : system clock, rising edge
//   rst       : synchronous reset, active-low
//   clr       : synchronous clear (counter held at 0)
//   last      : counter is on the final cycle of the bit period
//   near_last : counter is one cycle before the final cycle
module baud_tick_gen #(
  parameter int unsigned BAUD_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic last,
  output logic near_last
);

  localparam int unsigned CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt <= '0;
    end else if (last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last      = (cnt == CNT_W'(BAUD_DIV - 1));
  assign near_last = (cnt == CNT_W'(BAUD_DIV - 2));

endmodule

// File: rtl/fsk_symbol_sequencer.sv
// Frames a byte UART-style (start, DATA_W bits LSB-first, stop) and drives the
// 9-bit preloadable divider with the mark/space preload for each bit period.
//   clk       : system clock, rising edge
//   rst       : synchronous reset, active-low
//   din       : byte to transmit
//   din_valid : din is valid
//   din_ready : byte can be accepted (IDLE only)
//   cnt_ext   : preload value to the divider
//   init      : one-cycle divider preload strobe, only when cnt_ext changes
//   busy      : frame in progress (START..STOP)
//   tx_done   : one-cycle pulse on the last cycle of the stop bit
module fsk_symbol_sequencer
  import fsk_pkg::*;
#(
  parameter int unsigned          DATA_W        = 8,
  parameter int unsigned          BAUD_DIV      = 1000,
  parameter logic [PRELOAD_W-1:0] MARK_PRELOAD  = MARK_PRELOAD_DEF,
  parameter logic [PRELOAD_W-1:0] SPACE_PRELOAD = SPACE_PRELOAD_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [PRELOAD_W-1:0] cnt_ext,
  output logic                 init,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t               state, state_d;
  logic [DATA_W-1:0]    shreg, shreg_d;
  logic [IDX_W-1:0]     bit_idx, bit_idx_d;
  logic [PRELOAD_W-1:0] cnt_ext_d;
  logic                 bit_last, bit_near_last;

  // Counter is parked at 0 in IDLE so START always gets a full bit period.
  baud_tick_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .clk       (clk),
    .rst       (rst),
    .clr       (state == IDLE),
    .last      (bit_last),
    .near_last (bit_near_last)
  );

  // cnt_ext is registered, so the next preload is derived from the next state;
  // shreg_d[0] is the bit about to be sent after the boundary shift.
  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    bit_idx_d = bit_idx;
    cnt_ext_d = cnt_ext;
    unique case (state)
      IDLE: begin
        cnt_ext_d = MARK_PRELOAD;
        if (din_valid) begin
          state_d   = START;
          shreg_d   = din;
          cnt_ext_d = SPACE_PRELOAD;
        end
      end
      START: begin
        if (bit_last) begin
          state_d   = DATA;
          bit_idx_d = '0;
          cnt_ext_d = shreg[0] ? MARK_PRELOAD : SPACE_PRELOAD;
        end
      end
      DATA: begin
        if (bit_last) begin
          shreg_d = shreg >> 1;
          if (bit_idx == IDX_W'(DATA_W - 1)) begin
            state_d   = STOP;
            cnt_ext_d = MARK_PRELOAD;
          end else begin
            bit_idx_d = bit_idx + IDX_W'(1);
            cnt_ext_d = shreg_d[0] ? MARK_PRELOAD : SPACE_PRELOAD;
          end
        end
      end
      STOP: begin
        if (bit_last) begin
          state_d   = IDLE;
          cnt_ext_d = MARK_PRELOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      cnt_ext <= MARK_PRELOAD;
      init    <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      bit_idx <= bit_idx_d;
      cnt_ext <= cnt_ext_d;
      init    <= (cnt_ext_d != cnt_ext);
      busy    <= (state_d != IDLE);
      // Registered one cycle early so the pulse lands on the final STOP cycle.
      tx_done <= (state == STOP) && bit_near_last;
    end
  end

  assign din_ready = (state == IDLE) && !busy;

endmodule

// File: tb/tb_fsk_symbol_sequencer.sv
module tb_fsk_symbol_sequencer;
  import fsk_pkg::*;

  localparam logic [8:0] MARK  = 9'd256;
  localparam logic [8:0] SPACE = 9'd384;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [8:0] cnt_ext;
  logic       init;
  logic       busy;
  logic       tx_done;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [8:0] exp_slots [10];

  fsk_symbol_sequencer #(
    .DATA_W        (8),
    .BAUD_DIV      (4),
    .MARK_PRELOAD  (9'd256),
    .SPACE_PRELOAD (9'd384)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .cnt_ext   (cnt_ext),
    .init      (init),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input int unsigned exp_init);
    check({tag, ".cnt_ext"},   cnt_ext,   MARK);
    check({tag, ".init"},      init,      exp_init);
    check({tag, ".busy"},      busy,      0);
    check({tag, ".din_ready"}, din_ready, 1);
    check({tag, ".tx_done"},   tx_done,   0);
  endtask

  // First step is the accept edge; then 40 frame cycles, then one IDLE cycle.
  task automatic run_frame(input string tag, input int hold_from, input logic [7:0] next_din);
    logic [8:0] prev;
    int s;
    prev = MARK;
    step;
    din_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      s = c / 4;
      check({tag, ".cnt_ext"},   cnt_ext,   exp_slots[s]);
      check({tag, ".init"},      init,      (c % 4 == 0) && (exp_slots[s] != prev));
      check({tag, ".busy"},      busy,      1);
      check({tag, ".din_ready"}, din_ready, 0);
      check({tag, ".tx_done"},   tx_done,   c == 39);
      if (c % 4 == 3) prev = exp_slots[s];
      if (c == hold_from) begin
        din       = next_din;
        din_valid = 1'b1;
      end
      step;
    end
    check_idle({tag, ".after"}, 0);
  endtask

  initial begin
    // Reset held for three edges
    rst = 1'b0;
    repeat (3) step;
    check_idle("reset", 1);
    rst = 1'b1;
    step;
    check_idle("release", 0);
    step;
    check_idle("idle", 0);

    // 0xA5: start, 1,0,1,0,0,1,0,1, stop
    exp_slots = '{SPACE, MARK, SPACE, MARK, SPACE, SPACE, MARK, SPACE, MARK, MARK};
    din = 8'hA5;
    din_valid = 1'b1;
    run_frame("a5", -1, 8'h00);
    step;
    check_idle("a5.gap", 0);

    // 0xFF with a new byte 0x3C offered mid-frame and held
    exp_slots = '{SPACE, MARK, MARK, MARK, MARK, MARK, MARK, MARK, MARK, MARK};
    din = 8'hFF;
    din_valid = 1'b1;
    run_frame("ff", 5, 8'h3C);

    // 0x3C accepted straight out of the single IDLE cycle
    exp_slots = '{SPACE, SPACE, SPACE, MARK, MARK, MARK, MARK, SPACE, SPACE, MARK};
    run_frame("3c", -1, 8'h00);

    // Abort 0xA5 during data bit 3 (a space bit)
    exp_slots = '{SPACE, MARK, SPACE, MARK, SPACE, SPACE, MARK, SPACE, MARK, MARK};
    din = 8'hA5;
    din_valid = 1'b1;
    step;
    din_valid = 1'b0;
    for (int c = 0; c < 18; c++) begin
      check("abort.pre.cnt_ext", cnt_ext, exp_slots[c / 4]);
      if (c == 17) rst = 1'b0;
      step;
    end
    check_idle("abort", 1);
    rst = 1'b1;
    for (int c = 0; c < 45; c++) begin
      step;
      check_idle("abort.quiet", 0);
    end

    // Normal frame after the abort
    exp_slots = '{SPACE, SPACE, SPACE, MARK, MARK, MARK, MARK, SPACE, SPACE, MARK};
    din = 8'h3C;
    din_valid = 1'b1;
    run_frame("recover", -1, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
